// File: rtl/pulse_stretcher.sv
// pulse_stretcher: turns single-cycle trigger pulses into a high level of programmable width,
// followed by a programmable minimum low gap before the next pulse can start.
//
// Ports:
//   clk     - system clock, all state updates on the rising edge
//   rst     - synchronous active-high reset
//   in      - trigger request, sampled every rising edge
//   len     - high time in cycles (0 behaves as 1), sampled on trigger/retrigger edges
//   gap     - extra low time in cycles after each pulse, sampled when the pulse ends
//   retrig  - 1: a trigger while high restarts the high time; 0: it is dropped
//   out     - registered stretched pulse
//   busy    - high whenever the stretcher is not idle
//   overrun - one-cycle flag, a trigger was dropped at the previous edge
//   drops   - saturating count of dropped triggers since reset
module pulse_stretcher #(
    parameter int unsigned CW     = 8,
    parameter int unsigned DROP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in,
    input  logic [CW-1:0]     len,
    input  logic [CW-1:0]     gap,
    input  logic              retrig,
    output logic              out,
    output logic              busy,
    output logic              overrun,
    output logic [DROP_W-1:0] drops
);

    typedef enum logic [1:0] {StIdle, StHigh, StGap} state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CW-1:0]       gcnt_q, gcnt_d;
    logic                out_q, out_d;
    logic                busy_q, busy_d;
    logic                overrun_q, overrun_d;
    logic [DROP_W-1:0]   drops_q, drops_d;

    logic                drop;
    logic [CW-1:0]       len_eff;
    logic [CW-1:0]       len_load;

    // A zero length still produces a one-cycle pulse.
    assign len_eff  = (len == '0) ? CW'(1) : len;
    assign len_load = len_eff - CW'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        out_d   = out_q;
        drop    = 1'b0;

        unique case (state_q)
            StIdle: begin
                out_d = 1'b0;
                if (in) begin
                    state_d = StHigh;
                    cnt_d   = len_load;
                    out_d   = 1'b1;
                end
            end
            StHigh: begin
                out_d = 1'b1;
                // An accepted retrigger wins over expiry, even on the last high cycle.
                if (in && retrig) begin
                    cnt_d = len_load;
                end else begin
                    drop = in;
                    if (cnt_q == '0) begin
                        out_d = 1'b0;
                        if (gap != '0) begin
                            state_d = StGap;
                            gcnt_d  = gap - CW'(1);
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            StGap: begin
                out_d = 1'b0;
                drop  = in;
                if (gcnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    gcnt_d = gcnt_q - CW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                out_d   = 1'b0;
            end
        endcase
    end

    assign overrun_d = drop;
    assign drops_d   = (drop && (drops_q != {DROP_W{1'b1}})) ? drops_q + DROP_W'(1) : drops_q;
    assign busy_d    = (state_d != StIdle);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            gcnt_q    <= '0;
            out_q     <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            drops_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gcnt_q    <= gcnt_d;
            out_q     <= out_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
            drops_q   <= drops_d;
        end
    end

    assign out     = out_q;
    assign busy    = busy_q;
    assign overrun = overrun_q;
    assign drops   = drops_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Scoreboard bench for pulse_stretcher: a time-based reference model predicts the outputs
// after every edge, a monitor compares them half a cycle later.
module tb_pulse_stretcher;

    localparam int CW     = 8;
    localparam int DROP_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              in;
    logic [CW-1:0]     len;
    logic [CW-1:0]     gap;
    logic              retrig;
    logic              out;
    logic              busy;
    logic              overrun;
    logic [DROP_W-1:0] drops;

    pulse_stretcher #(.CW(CW), .DROP_W(DROP_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .in      (in),
        .len     (len),
        .gap     (gap),
        .retrig  (retrig),
        .out     (out),
        .busy    (busy),
        .overrun (overrun),
        .drops   (drops)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              out;
        logic              busy;
        logic              ov;
        logic [DROP_W-1:0] drops;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference model: remaining high cycles and remaining extra low cycles.
    int hi_left  = 0;
    int lo_left  = 0;
    int m_drops  = 0;
    bit m_ov     = 0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    task automatic model_drop();
        m_ov = 1;
        if (m_drops < (1 << DROP_W) - 1) m_drops++;
    endtask

    task automatic model_edge(input bit i, input int l, input int g, input bit r, input bit rs);
        int eff_len;
        eff_len = (l == 0) ? 1 : l;
        m_ov    = 0;
        if (rs) begin
            hi_left = 0;
            lo_left = 0;
            m_drops = 0;
        end else if (hi_left > 0) begin
            if (i && r) begin
                hi_left = eff_len;
            end else begin
                if (i) model_drop();
                hi_left--;
                if (hi_left == 0) lo_left = g;
            end
        end else if (lo_left > 0) begin
            if (i) model_drop();
            lo_left--;
        end else if (i) begin
            hi_left = eff_len;
        end
    endtask

    // One clock: drive at the falling edge, predict at the rising edge.
    task automatic step(input bit i, input int l, input int g, input bit r, input bit rs);
        exp_t e;
        in     = i;
        len    = CW'(l);
        gap    = CW'(g);
        retrig = r;
        rst    = rs;
        @(posedge clk);
        model_edge(i, l, g, r, rs);
        e.out   = (hi_left > 0);
        e.busy  = (hi_left > 0) || (lo_left > 0);
        e.ov    = m_ov;
        e.drops = DROP_W'(m_drops);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input int l, input int g, input bit r);
        for (int k = 0; k < n; k++) step(0, l, g, r, 0);
    endtask

    // Monitor: outputs are registered, so every edge presents a new sample.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("out", int'(out), int'(e.out));
                check("busy", int'(busy), int'(e.busy));
                check("overrun", int'(overrun), int'(e.ov));
                check("drops", int'(drops), int'(e.drops));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        in = 0; len = 0; gap = 0; retrig = 0; rst = 1;
        @(negedge clk);
        // Reset with a trigger present: trigger must be ignored.
        step(1, 3, 0, 0, 1);
        step(0, 3, 0, 0, 1);
        step(0, 3, 0, 0, 0);

        // Basic 3-cycle pulse, no gap.
        step(1, 3, 0, 0, 0);
        idle(6, 3, 0, 0);

        // len = 0 behaves as 1.
        step(1, 0, 0, 0, 0);
        idle(4, 0, 0, 0);

        // len 4, gap 2: drop in HIGH, drop in GAP, accept once idle.
        step(1, 4, 2, 0, 0);
        step(0, 4, 2, 0, 0);
        step(1, 4, 2, 0, 0);
        idle(3, 4, 2, 0);
        step(1, 4, 2, 0, 0);
        step(1, 4, 2, 0, 0);
        idle(8, 4, 2, 0);

        // Retrigger extends the pulse.
        step(1, 4, 0, 1, 0);
        idle(2, 4, 0, 1);
        step(1, 4, 0, 1, 0);
        idle(10, 4, 0, 1);

        // Reset mid-pulse with trigger held, then release.
        step(1, 10, 0, 0, 0);
        step(0, 10, 0, 0, 0);
        step(1, 10, 0, 0, 1);
        step(1, 10, 0, 0, 0);
        idle(14, 10, 0, 0);

        // Held trigger, len 1: toggling output and saturating drop count.
        for (int k = 0; k < 600; k++) step(1, 1, 0, 0, 0);
        idle(3, 1, 0, 0);

        // Held trigger with retrigger: output stays high.
        for (int k = 0; k < 20; k++) step(1, 2, 1, 1, 0);
        idle(6, 2, 1, 1);

        step(0, 0, 0, 0, 1);
        // Random traffic with parameters changing under a running pulse.
        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 9) < 3), int'($urandom_range(0, 6)),
                 int'($urandom_range(0, 4)), bit'($urandom_range(0, 1)),
                 ($urandom_range(0, 199) == 0));
        end
        idle(4, 0, 0, 0);

        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
